// File: rtl/bank_select_mem.sv
`default_nettype none
// ============================================================================
// Module   : bank_select_mem
// Brief    : Multi-port bank-select table with registered reads and an init
//            sweep. Define BANK_SELECT_MEM_BYPASS_EN for write-first reads.
// Revision : 1.0 - initial release
// ============================================================================
module bank_select_mem #(
    parameter int els_p        = 8,
    parameter int bank_width_p = 1,
    parameter int num_wr_p     = 2,
    parameter int num_rd_p     = 1,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_wr_p-1:0]                w_val_i,
    input  logic [num_wr_p*addr_width_lp-1:0]  w_addr_i,
    input  logic [num_wr_p*bank_width_p-1:0]   w_bank_i,
    output logic                               w_rdy_o,
    input  logic [num_rd_p-1:0]                r_val_i,
    input  logic [num_rd_p*addr_width_lp-1:0]  r_addr_i,
    output logic [num_rd_p-1:0]                r_val_o,
    output logic [num_rd_p*bank_width_p-1:0]   r_bank_o,
    input  logic                               init_req_i,
    input  logic [bank_width_p-1:0]            init_bank_i,
    output logic                               busy_o,
    output logic                               init_done_o
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SWEEP = 1'b1;
    localparam logic [addr_width_lp-1:0] c_LAST = addr_width_lp'(els_p - 1);

    logic [0:0]                        r_state;
    logic [addr_width_lp-1:0]          r_cnt;
    logic [bank_width_p-1:0]           r_init_bank;
    logic                              r_done;
    logic [bank_width_p-1:0]           r_mem     [els_p];
    logic [bank_width_p-1:0]           w_mem_nxt [els_p];
    logic [num_rd_p-1:0]               r_rd_val;
    logic [num_rd_p*bank_width_p-1:0]  r_rd_bank;
    logic [num_rd_p*bank_width_p-1:0]  w_rd_data;
    logic                              w_idle;

    assign w_idle      = (r_state == c_IDLE);
    assign w_rdy_o     = w_idle;
    assign busy_o      = ~w_idle;
    assign init_done_o = r_done;
    assign r_val_o     = r_rd_val;
    assign r_bank_o    = r_rd_bank;

    // Ports are applied highest-first so the lowest accepted port lands last and wins.
    always_comb begin
        w_mem_nxt = r_mem;
        for (int e = 0; e < els_p; e++) begin
            if (w_idle) begin
                for (int p = num_wr_p - 1; p >= 0; p--) begin
                    if (w_val_i[p] && (w_addr_i[p*addr_width_lp +: addr_width_lp] == addr_width_lp'(e))) begin
                        w_mem_nxt[e] = w_bank_i[p*bank_width_p +: bank_width_p];
                    end
                end
            end else if (r_cnt == addr_width_lp'(e)) begin
                w_mem_nxt[e] = r_init_bank;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int q = 0; q < num_rd_p; q++) begin
            for (int e = 0; e < els_p; e++) begin
                if (r_addr_i[q*addr_width_lp +: addr_width_lp] == addr_width_lp'(e)) begin
`ifdef BANK_SELECT_MEM_BYPASS_EN
                    w_rd_data[q*bank_width_p +: bank_width_p] = w_mem_nxt[e];
`else
                    w_rd_data[q*bank_width_p +: bank_width_p] = r_mem[e];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int e = 0; e < els_p; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            r_mem <= w_mem_nxt;
        end
    end

    // Read bank holds its previous value on cycles without a request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_val  <= '0;
            r_rd_bank <= '0;
        end else begin
            r_rd_val <= r_val_i;
            for (int q = 0; q < num_rd_p; q++) begin
                if (r_val_i[q]) begin
                    r_rd_bank[q*bank_width_p +: bank_width_p] <= w_rd_data[q*bank_width_p +: bank_width_p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_init_bank <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (init_req_i) begin
                        r_state     <= c_SWEEP;
                        r_cnt       <= '0;
                        r_init_bank <= init_bank_i;
                    end
                end
                c_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
